imem_loader: RTL and testbench

- Writer side of the instruction-memory interface. The fetch stage only reads program memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words into instruction memory at BASE_ADDR, BASE_ADDR+4, and so on.
- Holds the core in reset while loading and signals completion or error at the end.

---
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction memory with 32-bit words
//
// Purpose:
//   Receives a byte stream over a valid/ready handshake. The first four bytes
//   form a little-endian word count N. Each following group of four bytes is
//   assembled little-endian into a word and written to instruction memory at
//   BASE_ADDR, BASE_ADDR+4, and so on. The core is held in reset while a load
//   is in progress, and also after a rejected header.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   start_i        begins a load from IDLE, DONE or ERROR
//   byte_i         stream byte
//   byte_valid_i   byte_i is valid
//   byte_ready_o   loader accepts a byte this cycle (registered)
//   mem_addr_o     instruction memory write address
//   mem_data_o     instruction memory write data
//   mem_write_en_o one-cycle write strobe
//   core_hold_o    holds the core in reset while loading or after an error
//   busy_o         load in progress
//   done_o         load completed (level)
//   error_o        header rejected (level, until the next start)
//   words_o        words written so far in this load

module imem_loader #(
   parameter int                AWIDTH    = 32,
   parameter int                DWIDTH    = 32,
   parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000),
   parameter int                MAX_WORDS = 16384
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_write_en_o,
   output logic              core_hold_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [31:0]       words_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state;
   state_t            state_nx;

   logic [1:0]        byte_idx;
   logic [31:0]       hdr_n;
   logic [DWIDTH-1:0] word_buf;
   logic [31:0]       words;
   logic              ready;

   logic              xfer;
   logic              last_byte;
   logic              load_start;
   logic [31:0]       hdr_full;
   logic [31:0]       words_inc;

   assign xfer      = byte_valid_i & ready;
   assign last_byte = xfer & (byte_idx == 2'd3);
   // Complete header value as it will be once the current (4th) byte lands.
   assign hdr_full  = {byte_i, hdr_n[23:0]};
   assign words_inc = words + 32'd1;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx   = state;
      load_start = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_i) begin
               state_nx   = S_HDR;
               load_start = 1'b1;
            end
         end
         S_HDR: begin
            if (last_byte) begin
               if (hdr_full == 32'd0) begin
                  state_nx = S_DONE;
               end else if (hdr_full > 32'(MAX_WORDS)) begin
                  state_nx = S_ERROR;
               end else begin
                  state_nx = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (last_byte) begin
               state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            state_nx = (words_inc == hdr_n) ? S_DONE : S_DATA;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Datapath: byte assembly, word counter and registered ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_idx <= 2'd0;
         hdr_n    <= 32'd0;
         word_buf <= '0;
         words    <= 32'd0;
         ready    <= 1'b0;
      end else begin
         // Ready follows the state being entered, so it is high exactly in
         // HDR and DATA and already low during the WRITE cycle.
         ready <= (state_nx == S_HDR) || (state_nx == S_DATA);

         if (load_start) begin
            byte_idx <= 2'd0;
            words    <= 32'd0;
         end

         // Index wraps 3 -> 0 on its own, which re-arms the next word.
         if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            if (state == S_HDR) begin
               hdr_n[{byte_idx, 3'b000} +: 8] <= byte_i;
            end else begin
               word_buf[{byte_idx, 3'b000} +: 8] <= byte_i;
            end
         end

         if (state == S_WRITE) begin
            words <= words_inc;
         end
      end
   end

   // Outputs decode directly from registers, so reset clears them at once.
   assign byte_ready_o   = ready;
   assign mem_write_en_o = (state == S_WRITE);
   assign mem_addr_o     = BASE_ADDR + AWIDTH'({words, 2'b00});
   assign mem_data_o     = word_buf;
   assign busy_o         = (state == S_HDR) || (state == S_DATA) || (state == S_WRITE);
   // ERROR keeps the hold so a partially loaded program never executes.
   assign core_hold_o    = busy_o || (state == S_ERROR);
   assign done_o         = (state == S_DONE);
   assign error_o        = (state == S_ERROR);
   assign words_o        = words;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader

module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h0100_0000;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [7:0]  byte_i;
   logic        byte_valid_i;
   logic        byte_ready_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_write_en_o;
   logic        core_hold_o;
   logic        busy_o;
   logic        done_o;
   logic        error_o;
   logic [31:0] words_o;

   imem_loader dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .byte_i         (byte_i),
      .byte_valid_i   (byte_valid_i),
      .byte_ready_o   (byte_ready_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_write_en_o (mem_write_en_o),
      .core_hold_o    (core_hold_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .error_o        (error_o),
      .words_o        (words_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [31:0] mem[logic [31:0]];

   int   cyc = 0;
   int   last_we_cyc = 0;
   int   we_gap = 0;
   int   ready_viol = 0;
   int   long_strobe = 0;
   logic prev_we = 1'b0;

   // Scoreboard: every strobe pops the oldest expected write and compares.
   always @(negedge clk) begin
      logic [31:0] ea, ed;
      if (mem_write_en_o === 1'b1) begin
         n_checks++;
         if (exp_addr.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write got %h:%h required no write", mem_addr_o, mem_data_o);
         end else begin
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            if (mem_addr_o !== ea || mem_data_o !== ed) begin
               n_fail++;
               $display("FAIL write_compare got %h:%h required %h:%h", mem_addr_o, mem_data_o, ea, ed);
            end
         end
         mem[mem_addr_o] = mem_data_o;
         if (byte_ready_o) ready_viol++;
         if (prev_we) long_strobe++;
         we_gap      = cyc - last_we_cyc;
         last_we_cyc = cyc;
      end
      prev_we = mem_write_en_o;
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Presents one byte and returns at the negedge after it transferred.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int k;
      int t;
      if (gap > 0) begin
         k = $urandom_range(gap, 0);
         if (k > 0) begin
            byte_valid_i = 1'b0;
            byte_i       = 8'hxx;
            repeat (k) @(negedge clk);
         end
      end
      byte_i       = b;
      byte_valid_i = 1'b1;
      t = 0;
      while (!byte_ready_o && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (!byte_ready_o) begin
         n_fail++;
         $display("FAIL send_byte_timeout got ready=%b required 1", byte_ready_o);
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic wait_end();
      byte_valid_i = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (done_o || error_o) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start_i = 1'b0; byte_i = 8'h00; byte_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({byte_ready_o, mem_write_en_o, busy_o, done_o, error_o, core_hold_o} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b required 000000",
                  {byte_ready_o, mem_write_en_o, busy_o, done_o, error_o, core_hold_o});
      end
      n_checks++;
      if (mem_addr_o !== BASE || mem_data_o !== 32'h0 || words_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_values got %h/%h/%0d required %h/0/0", mem_addr_o, mem_data_o, words_o, BASE);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset got busy=%b ready=%b required 0 0", busy_o, byte_ready_o);
      end
   endtask

   task automatic test_two_words();
      pulse_start();
      n_checks++;
      if (busy_o !== 1'b1 || core_hold_o !== 1'b1) begin
         n_fail++;
         $display("FAIL hdr_busy got busy=%b hold=%b required 1 1", busy_o, core_hold_o);
      end
      exp_addr.push_back(BASE);        exp_data.push_back(32'h0000_0513);
      exp_addr.push_back(BASE + 32'd4); exp_data.push_back(32'h0010_0593);
      send_word(32'h0000_0002, 0);
      send_word(32'h0000_0513, 0);
      send_word(32'h0010_0593, 0);
      wait_end();
      n_checks++;
      if (done_o !== 1'b1 || core_hold_o !== 1'b0 || busy_o !== 1'b0 || words_o !== 32'd2) begin
         n_fail++;
         $display("FAIL two_words_end got done=%b hold=%b busy=%b words=%0d required 1 0 0 2",
                  done_o, core_hold_o, busy_o, words_o);
      end
      n_checks++;
      if (exp_addr.size() != 0) begin
         n_fail++;
         $display("FAIL two_words_missing got %0d pending required 0", exp_addr.size());
      end
      n_checks++;
      if (we_gap != 5) begin
         n_fail++;
         $display("FAIL throughput got %0d cycles required 5", we_gap);
      end
      n_checks++;
      if (long_strobe != 0) begin
         n_fail++;
         $display("FAIL strobe_width got %0d long strobes required 0", long_strobe);
      end
   endtask

   task automatic test_zero_header();
      pulse_start();
      send_word(32'h0000_0000, 0);
      wait_end();
      repeat (3) @(negedge clk);
      n_checks++;
      if (done_o !== 1'b1 || words_o !== 32'd0 || error_o !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_header got done=%b words=%0d error=%b required 1 0 0", done_o, words_o, error_o);
      end
   endtask

   task automatic test_bad_header();
      pulse_start();
      send_word(32'h0000_4001, 0);
      wait_end();
      repeat (3) @(negedge clk);
      n_checks++;
      if (error_o !== 1'b1 || core_hold_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_header got err=%b hold=%b busy=%b done=%b required 1 1 0 0",
                  error_o, core_hold_o, busy_o, done_o);
      end
      pulse_start();
      n_checks++;
      if (error_o !== 1'b0 || busy_o !== 1'b1 || byte_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL error_restart got err=%b busy=%b ready=%b required 0 1 1", error_o, busy_o, byte_ready_o);
      end
      send_word(32'h0000_0000, 0);
      wait_end();
      n_checks++;
      if (done_o !== 1'b1) begin
         n_fail++;
         $display("FAIL error_recover got done=%b required 1", done_o);
      end
   endtask

   task automatic test_gaps();
      logic [31:0] w[4];
      w[0] = 32'hDEAD_BEEF; w[1] = 32'h1234_5678; w[2] = 32'h0000_0001; w[3] = 32'hA5A5_5A5A;
      ready_viol = 0;
      pulse_start();
      send_word(32'h0000_0004, 3);
      for (int i = 0; i < 4; i++) begin
         exp_addr.push_back(BASE + 32'(4 * i));
         exp_data.push_back(w[i]);
         send_word(w[i], 3);
      end
      wait_end();
      n_checks++;
      if (done_o !== 1'b1 || words_o !== 32'd4 || exp_addr.size() != 0) begin
         n_fail++;
         $display("FAIL gaps_end got done=%b words=%0d pending=%0d required 1 4 0", done_o, words_o, exp_addr.size());
      end
      n_checks++;
      if (ready_viol != 0) begin
         n_fail++;
         $display("FAIL ready_in_write got %0d required 0", ready_viol);
      end
   endtask

   task automatic test_reset_mid_load();
      mem.delete();
      pulse_start();
      send_word(32'h0000_0003, 0);
      exp_addr.push_back(BASE); exp_data.push_back(32'h0BAD_F00D);
      send_word(32'h0BAD_F00D, 0);
      send_byte(8'h10, 0);
      send_byte(8'h32, 0);
      byte_valid_i = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({byte_ready_o, mem_write_en_o, busy_o, done_o, error_o, core_hold_o} !== 6'b0) begin
         n_fail++;
         $display("FAIL async_reset_flags got %b required 000000",
                  {byte_ready_o, mem_write_en_o, busy_o, done_o, error_o, core_hold_o});
      end
      n_checks++;
      if (mem_addr_o !== BASE || mem_data_o !== 32'h0 || words_o !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset_values got %h/%h/%0d required %h/0/0", mem_addr_o, mem_data_o, words_o, BASE);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (!mem.exists(BASE) || mem.exists(BASE + 32'd4) || exp_addr.size() != 0) begin
         n_fail++;
         $display("FAIL partial_word got w0=%0d w1=%0d pending=%0d required 1 0 0",
                  mem.exists(BASE), mem.exists(BASE + 32'd4), exp_addr.size());
      end
      pulse_start();
      send_word(32'h0000_0001, 0);
      exp_addr.push_back(BASE); exp_data.push_back(32'hCAFE_BABE);
      send_word(32'hCAFE_BABE, 0);
      wait_end();
      n_checks++;
      if (done_o !== 1'b1 || words_o !== 32'd1 || mem[BASE] !== 32'hCAFE_BABE) begin
         n_fail++;
         $display("FAIL reload got done=%b words=%0d mem=%h required 1 1 cafebabe", done_o, words_o, mem[BASE]);
      end
   endtask

   task automatic test_start_in_data();
      pulse_start();
      send_word(32'h0000_0002, 0);
      exp_addr.push_back(BASE);        exp_data.push_back(32'h1122_3344);
      exp_addr.push_back(BASE + 32'd4); exp_data.push_back(32'h5566_7788);
      send_byte(8'h44, 0);
      send_byte(8'h33, 0);
      start_i = 1'b1;
      send_byte(8'h22, 0);
      send_byte(8'h11, 0);
      send_byte(8'h88, 0);
      start_i = 1'b0;
      send_byte(8'h77, 0);
      send_byte(8'h66, 0);
      send_byte(8'h55, 0);
      wait_end();
      n_checks++;
      if (done_o !== 1'b1 || words_o !== 32'd2 || exp_addr.size() != 0) begin
         n_fail++;
         $display("FAIL start_ignored got done=%b words=%0d pending=%0d required 1 2 0", done_o, words_o, exp_addr.size());
      end
   endtask

   initial begin
      test_reset();
      test_two_words();
      test_zero_header();
      test_bad_header();
      test_gaps();
      test_reset_mid_load();
      test_start_in_data();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
